// File: rtl/axi_wr_responder_pkg.sv
// Shared AXI constants for the data-cache write path.
// Pure declarations; no timing or flow-control behaviour.
package axi_wr_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // AXI bursts must not cross a 4 KiB page.
  localparam int unsigned PAGE_BITS = 12;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next INCR beat address: current address aligned down to 2**size, plus 2**size.
// Purely combinational, no flow control; wraps modulo 2**AddrWidth.
module axi_burst_addr_gen #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  output logic [AddrWidth-1:0] next_addr
);

  logic [AddrWidth-1:0] step;

  assign step      = AddrWidth'(1) << size;
  assign next_addr = (addr & ~(step - AddrWidth'(1))) + step;

endmodule

// File: rtl/axi_wr_responder.sv
// AXI write responder for the data cache: one outstanding burst, beats forwarded to memory.
// W->mem is combinational (zero added latency); w_ready follows mem_gnt; B held until b_ready.
module axi_wr_responder
  import axi_wr_responder_pkg::*;
#(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter logic [63:0] RegionBase   = 64'h8000_0000,
  parameter logic [63:0] RegionLength = 64'h4000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
  input  logic [5:0]             aw_atop_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  localparam int unsigned MaxSize = $clog2(DataWidth / 8);
  localparam logic [AddrWidth:0] RegionLo = (AddrWidth + 1)'(RegionBase);
  localparam logic [AddrWidth:0] RegionHi =
      (AddrWidth + 1)'({1'b0, RegionBase} + {1'b0, RegionLength});

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [7:0]           cnt_q;
  logic                 err_q;

  logic                 aw_hs, w_hs, b_hs;
  logic                 in_region, size_bad, page_cross, aw_err, last_err;
  logic [AddrWidth-1:0] aw_step, aw_last_addr, next_addr;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i & w_ready_o;
  assign b_hs  = b_valid_o & b_ready_i;

  // Request legality is decided once, at AW acceptance, from the raw AW fields.
  assign in_region    = ({1'b0, aw_addr_i} >= RegionLo) && ({1'b0, aw_addr_i} < RegionHi);
  assign size_bad     = aw_size_i > 3'(MaxSize);
  assign aw_step      = AddrWidth'(1) << aw_size_i;
  assign aw_last_addr = (aw_addr_i & ~(aw_step - AddrWidth'(1)))
                      + (AddrWidth'(aw_len_i) << aw_size_i);
  assign page_cross   = aw_addr_i[AddrWidth-1:PAGE_BITS] != aw_last_addr[AddrWidth-1:PAGE_BITS];
  assign aw_err       = !in_region || (aw_atop_i != 6'd0) || (aw_burst_i != BURST_INCR)
                      || size_bad || page_cross;

  assign last_err = w_last_i != (cnt_q == len_q);

  axi_burst_addr_gen #(
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && w_last_i) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    mem_req_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_id_o     = '0;
    b_resp_o   = RESP_OKAY;
    case (state_q)
      IDLE: aw_ready_o = 1'b1;
      DATA: begin
        if (err_q) begin
          w_ready_o = 1'b1;
        end else begin
          w_ready_o = mem_gnt_i;
          mem_req_o = w_valid_i;
        end
      end
      RESP: begin
        b_valid_o = 1'b1;
        b_id_o    = id_q;
        b_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Error flag stays sticky through RESP and is only rewritten by the next AW.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (aw_hs) begin
      id_q    <= aw_id_i;
      addr_q  <= aw_addr_i;
      len_q   <= aw_len_i;
      size_q  <= aw_size_i;
      burst_q <= aw_burst_i;
      cnt_q   <= '0;
      err_q   <= aw_err;
    end else if (state_q == DATA && w_hs) begin
      if (last_err) err_q <= 1'b1;
      if (!w_last_i) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= (burst_q == BURST_INCR) ? next_addr : addr_q;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = w_data_i;
  assign mem_be_o    = w_strb_i;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed table-driven bench for axi_wr_responder plus a reset-mid-burst sequence.
// Inputs change 1ns after posedge; outputs are compared on the falling edge.
module tb_axi_wr_responder;

  localparam logic [63:0] B    = 64'h8000_0000;
  localparam logic [1:0]  OK   = 2'b00;
  localparam logic [1:0]  ERR  = 2'b10;
  localparam logic [1:0]  INCR = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [5:0]  aw_atop;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        mem_req, mem_gnt;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_wr_responder #(
    .IdWidth      (4),
    .AddrWidth    (64),
    .DataWidth    (64),
    .RegionBase   (64'h8000_0000),
    .RegionLength (64'h4000_0000)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .aw_valid_i  (aw_valid),
    .aw_ready_o  (aw_ready),
    .aw_id_i     (aw_id),
    .aw_addr_i   (aw_addr),
    .aw_len_i    (aw_len),
    .aw_size_i   (aw_size),
    .aw_burst_i  (aw_burst),
    .aw_atop_i   (aw_atop),
    .w_valid_i   (w_valid),
    .w_ready_o   (w_ready),
    .w_data_i    (w_data),
    .w_strb_i    (w_strb),
    .w_last_i    (w_last),
    .b_valid_o   (b_valid),
    .b_ready_i   (b_ready),
    .b_id_o      (b_id),
    .b_resp_o    (b_resp),
    .mem_req_o   (mem_req),
    .mem_gnt_i   (mem_gnt),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be)
  );

  typedef struct {
    string       name;
    logic        awv;
    logic [63:0] awaddr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic [3:0]  id;
    logic        wv;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        wlast;
    logic        gnt;
    logic        bready;
    logic        e_awr;
    logic        e_wr;
    logic        e_mreq;
    logic [63:0] e_maddr;
    logic        e_bv;
    logic [1:0]  e_bresp;
    logic [3:0]  e_bid;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic awv, logic [63:0] awaddr, logic [7:0] len,
                              logic [2:0] size, logic [1:0] burst, logic [5:0] atop, logic [3:0] id,
                              logic wv, logic [63:0] wdata, logic [7:0] strb, logic wlast,
                              logic gnt, logic bready, logic e_awr, logic e_wr, logic e_mreq,
                              logic [63:0] e_maddr, logic e_bv, logic [1:0] e_bresp, logic [3:0] e_bid);
    vec_t v;
    v.name = name; v.awv = awv; v.awaddr = awaddr; v.len = len; v.size = size;
    v.burst = burst; v.atop = atop; v.id = id; v.wv = wv; v.wdata = wdata; v.strb = strb;
    v.wlast = wlast; v.gnt = gnt; v.bready = bready; v.e_awr = e_awr; v.e_wr = e_wr;
    v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_bv = e_bv; v.e_bresp = e_bresp; v.e_bid = e_bid;
    return v;
  endfunction

  // IDLE cycle presenting a new AW; mem_addr still shows the previous burst's address.
  function automatic vec_t aw_row(string name, logic [63:0] addr, logic [7:0] len, logic [2:0] size,
                                  logic [1:0] burst, logic [5:0] atop, logic [3:0] id, logic [63:0] e_maddr);
    return mk(name, 1, addr, len, size, burst, atop, id, 0, 64'h0, 8'h00, 0, 1, 0,
              1, 0, 0, e_maddr, 0, OK, 4'h0);
  endfunction

  // DATA cycle with a valid beat: an errored burst drains (ready=1, no req).
  function automatic vec_t w_row(string name, logic [63:0] data, logic [7:0] strb, logic last,
                                 logic gnt, logic err, logic [63:0] e_maddr);
    return mk(name, 0, 64'h0, 8'h0, 3'h0, 2'h0, 6'h0, 4'h0, 1, data, strb, last, gnt, 0,
              0, err ? 1'b1 : gnt, !err, e_maddr, 0, OK, 4'h0);
  endfunction

  function automatic vec_t b_row(string name, logic bready, logic [1:0] resp, logic [3:0] id,
                                 logic [63:0] e_maddr);
    return mk(name, 0, 64'h0, 8'h0, 3'h0, 2'h0, 6'h0, 4'h0, 0, 64'h0, 8'h00, 0, 0, bready,
              0, 0, 0, e_maddr, 1, resp, id);
  endfunction

  task automatic apply(input vec_t v);
    aw_valid = v.awv; aw_addr = v.awaddr; aw_len = v.len; aw_size = v.size;
    aw_burst = v.burst; aw_atop = v.atop; aw_id = v.id;
    w_valid = v.wv; w_data = v.wdata; w_strb = v.strb; w_last = v.wlast;
    mem_gnt = v.gnt; b_ready = v.bready;
  endtask

  task automatic idle_inputs();
    aw_valid = 0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_atop = '0; aw_id = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; mem_gnt = 0; b_ready = 0;
  endtask

  function automatic logic [81:0] observed();
    return {aw_ready, w_ready, mem_req, mem_addr, mem_be, b_valid, b_resp, b_id};
  endfunction

  task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    // ---------------- vector table ----------------
    vq.push_back(mk("reset_idle", 0, 64'h0, 8'h0, 3'h0, 2'h0, 6'h0, 4'h0, 0, 64'h0, 8'h00, 0, 0, 0,
                    1, 0, 0, 64'h0, 0, OK, 4'h0));
    // single beat, immediate grant: B on cycle 2
    vq.push_back(aw_row("t1_aw", B, 8'd0, 3'd3, INCR, 6'h0, 4'h3, 64'h0));
    vq.push_back(w_row("t1_w", 64'hDEAD_BEEF, 8'hFF, 1, 1, 0, B));
    vq.push_back(b_row("t1_b", 1, OK, 4'h3, B));
    // 4-beat INCR, grant low for two cycles per beat
    vq.push_back(aw_row("t2_aw", B + 64'h10, 8'd3, 3'd3, INCR, 6'h0, 4'h5, B));
    for (int beat = 0; beat < 4; beat++) begin
      for (int g = 0; g < 3; g++) begin
        if (beat == 0 && g == 0)
          vq.push_back(mk("t2_aw_in_data_ignored", 1, 64'h1234, 8'h0, 3'h3, INCR, 6'h0, 4'hF,
                          1, 64'hA0, 8'h0F, 0, 0, 0, 0, 0, 1, B + 64'h10, 0, OK, 4'h0));
        else
          vq.push_back(w_row($sformatf("t2_w%0d_g%0d", beat, g), 64'hA0 + 64'(beat),
                             8'h0F ^ 8'(beat), beat == 3, g == 2, 0, B + 64'h10 + 64'(8 * beat)));
      end
    end
    vq.push_back(b_row("t2_b", 1, OK, 4'h5, B + 64'h28));
    // out of region
    vq.push_back(aw_row("t3_aw", 64'h1000, 8'd1, 3'd3, INCR, 6'h0, 4'h6, B + 64'h28));
    vq.push_back(w_row("t3_w0", 64'h11, 8'hFF, 0, 0, 1, 64'h1000));
    vq.push_back(w_row("t3_w1", 64'h22, 8'hFF, 1, 0, 1, 64'h1008));
    vq.push_back(b_row("t3_b", 1, ERR, 4'h6, 64'h1008));
    // 4 KiB crossing
    vq.push_back(aw_row("t4_aw", B + 64'hFF8, 8'd1, 3'd3, INCR, 6'h0, 4'h7, 64'h1008));
    vq.push_back(w_row("t4_w0", 64'h33, 8'hFF, 0, 1, 1, B + 64'hFF8));
    vq.push_back(w_row("t4_w1", 64'h44, 8'hFF, 1, 1, 1, B + 64'h1000));
    vq.push_back(b_row("t4_b", 1, ERR, 4'h7, B + 64'h1000));
    // early w_last on len 2, then B held under backpressure
    vq.push_back(aw_row("t5_aw", B + 64'h100, 8'd2, 3'd3, INCR, 6'h0, 4'h9, B + 64'h1000));
    vq.push_back(w_row("t5_w0", 64'h55, 8'hF0, 0, 1, 0, B + 64'h100));
    vq.push_back(w_row("t5_w1_early_last", 64'h66, 8'h0F, 1, 1, 0, B + 64'h108));
    for (int i = 0; i < 5; i++)
      vq.push_back(b_row($sformatf("t5_b_stall%0d", i), 0, ERR, 4'h9, B + 64'h108));
    vq.push_back(b_row("t5_b", 1, ERR, 4'h9, B + 64'h108));
    vq.push_back(mk("t5_idle_w_ignored", 0, 64'h0, 8'h0, 3'h0, 2'h0, 6'h0, 4'h0, 1, 64'h77, 8'h3C, 1, 1, 0,
                    1, 0, 0, B + 64'h108, 0, OK, 4'h0));
    // atomic, oversize, FIXED burst
    vq.push_back(aw_row("t6_aw_atop", B + 64'h40, 8'd0, 3'd3, INCR, 6'h01, 4'h2, B + 64'h108));
    vq.push_back(w_row("t6_w", 64'h88, 8'hFF, 1, 1, 1, B + 64'h40));
    vq.push_back(b_row("t6_b", 1, ERR, 4'h2, B + 64'h40));
    vq.push_back(aw_row("t7_aw_size4", B + 64'h80, 8'd0, 3'd4, INCR, 6'h0, 4'h4, B + 64'h40));
    vq.push_back(w_row("t7_w", 64'h99, 8'hFF, 1, 1, 1, B + 64'h80));
    vq.push_back(b_row("t7_b", 1, ERR, 4'h4, B + 64'h80));
    vq.push_back(aw_row("t8_aw_fixed", B + 64'hC0, 8'd0, 3'd3, 2'b00, 6'h0, 4'h1, B + 64'h80));
    vq.push_back(w_row("t8_w", 64'hAA, 8'hFF, 1, 1, 1, B + 64'hC0));
    vq.push_back(b_row("t8_b", 1, ERR, 4'h1, B + 64'hC0));
    // region edges: last in-region word, first word past the region
    vq.push_back(aw_row("t9_aw_top", 64'hBFFF_FFF8, 8'd0, 3'd3, INCR, 6'h0, 4'hA, B + 64'hC0));
    vq.push_back(w_row("t9_w", 64'hBB, 8'hFF, 1, 1, 0, 64'hBFFF_FFF8));
    vq.push_back(b_row("t9_b", 1, OK, 4'hA, 64'hBFFF_FFF8));
    vq.push_back(aw_row("t10_aw_end", 64'hC000_0000, 8'd0, 3'd3, INCR, 6'h0, 4'hB, 64'hBFFF_FFF8));
    vq.push_back(w_row("t10_w", 64'hCC, 8'hFF, 1, 1, 1, 64'hC000_0000));
    vq.push_back(b_row("t10_b", 1, ERR, 4'hB, 64'hC000_0000));

    // ---------------- reset ----------------
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", observed(), {1'b1, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00, 4'h0});
    @(posedge clk); #1 rst_n = 1'b1;

    // ---------------- table ----------------
    foreach (vq[i]) begin
      @(posedge clk); #1;
      apply(vq[i]);
      @(negedge clk);
      chk(vq[i].name, observed(),
          {vq[i].e_awr, vq[i].e_wr, vq[i].e_mreq, vq[i].e_maddr, vq[i].strb,
           vq[i].e_bv, vq[i].e_bresp, vq[i].e_bid});
    end

    // ---------------- reset during DATA ----------------
    @(posedge clk); #1;
    idle_inputs();
    aw_valid = 1; aw_addr = B + 64'h200; aw_len = 8'd3; aw_size = 3'd3; aw_burst = INCR; aw_id = 4'hC;
    @(posedge clk); #1;
    idle_inputs();
    w_valid = 1; w_data = 64'h1; w_strb = 8'hFF; mem_gnt = 1;
    @(negedge clk);
    chk("rst_seq_beat0", 82'({mem_req, mem_addr}), 82'({1'b1, B + 64'h200}));
    @(posedge clk); #1;
    w_data = 64'h2;
    @(negedge clk);
    chk("rst_seq_beat1", 82'({mem_req, mem_addr}), 82'({1'b1, B + 64'h208}));
    @(posedge clk); #1;
    idle_inputs();
    b_ready = 1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_seq_in_reset", observed(), {1'b1, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 2'b00, 4'h0});
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_no_b%0d", i), 82'({aw_ready, b_valid, w_ready}), 82'(3'b100));
      @(posedge clk); #1;
    end
    aw_valid = 1; aw_addr = B + 64'h300; aw_len = 8'd0; aw_size = 3'd3; aw_burst = INCR; aw_id = 4'hD;
    @(posedge clk); #1;
    idle_inputs();
    w_valid = 1; w_data = 64'h3; w_strb = 8'h5A; w_last = 1; mem_gnt = 1; b_ready = 1;
    @(negedge clk);
    chk("rst_seq_next_w", 82'({mem_req, w_ready, mem_addr, mem_be}), 82'({1'b1, 1'b1, B + 64'h300, 8'h5A}));
    @(posedge clk); #1;
    idle_inputs();
    b_ready = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (b_valid) begin
        found = 1'b1;
        chk("rst_seq_next_b", 82'({b_resp, b_id}), 82'({OK, 4'hD}));
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("rst_seq_b_seen", 82'(found), 82'(1'b1));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rst_seq_back_idle", 82'({aw_ready, b_valid}), 82'(2'b10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_responder.md
AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

Interface
REQ-001 SHALL have parameter IdWidth, default 4: AXI ID width.
REQ-002 SHALL have parameter AddrWidth, default 64: AXI address width.
REQ-003 SHALL have parameter DataWidth, default 64: AXI data width; mem_be_o is DataWidth/8 bits wide.
REQ-004 SHALL have parameter RegionBase, default 64'h8000_0000: base of the accepted cached region.
REQ-005 SHALL have parameter RegionLength, default 64'h4000_0000: size of the accepted region.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have AW ports: aw_valid_i in 1; aw_ready_o out 1; aw_id_i in IdWidth; aw_addr_i in AddrWidth; aw_len_i in 8; aw_size_i in 3; aw_burst_i in 2; aw_atop_i in 6.
REQ-009 SHALL have W ports: w_valid_i in 1; w_ready_o out 1; w_data_i in DataWidth; w_strb_i in DataWidth/8; w_last_i in 1.
REQ-010 SHALL have B ports: b_valid_o out 1; b_ready_i in 1; b_id_o out IdWidth; b_resp_o out 2.
REQ-011 SHALL have memory ports: mem_req_o out 1; mem_gnt_i in 1; mem_addr_o out AddrWidth; mem_wdata_o out DataWidth; mem_be_o out DataWidth/8.

Function
REQ-012 SHALL be the responder end of the data-cache AXI write path, with one outstanding write transaction.
REQ-013 SHALL implement the FSM IDLE -> DATA -> RESP -> IDLE.
REQ-014 In IDLE, aw_ready_o SHALL be 1 and w_ready_o SHALL be 0.
REQ-015 On an AW handshake, SHALL capture id, addr, len, size and burst, then enter DATA the next cycle.
REQ-016 SHALL set the captured error flag if any of these hold:
- address outside [RegionBase, RegionBase+RegionLength);
- aw_atop_i != 0;
- burst != INCR;
- 2**size > DataWidth/8;
- the burst crosses a 4 KiB boundary.
REQ-017 In DATA with no error, mem_req_o SHALL equal w_valid_i and w_ready_o SHALL equal mem_gnt_i, combinationally with zero added latency.
REQ-018 mem_wdata_o SHALL equal w_data_i, and mem_be_o SHALL equal w_strb_i.
REQ-019 In DATA with the error flag set, w_ready_o SHALL be 1, mem_req_o SHALL be 0, and beats SHALL be drained without any memory write.
REQ-020 mem_addr_o SHALL use the captured address for beat 0; each later beat SHALL use the previous address aligned down to 2**size plus 2**size, computed modulo 2**AddrWidth.
REQ-021 SHALL count beats with an 8-bit counter.
REQ-022 SHALL set the error flag if w_last_i disagrees with (count == len), and SHALL complete the burst on the w_last_i handshake regardless.
REQ-023 On the w_last_i handshake, SHALL enter RESP the next cycle.
REQ-024 In RESP, b_valid_o SHALL be 1 with b_id_o = captured id and b_resp_o = SLVERR (2'b10) if the error flag is set, else OKAY (2'b00).
REQ-025 b_valid_o, b_id_o and b_resp_o SHALL hold stable until b_ready_i; the module SHALL return to IDLE on the cycle after the handshake.
REQ-026 SHALL ignore W beats presented in IDLE (not accepted) and AW requests presented in DATA or RESP (aw_ready_o = 0).
REQ-027 Minimum latency for a single-beat write with an immediate grant SHALL be: AW handshake cycle 0, W handshake cycle 1, b_valid_o cycle 2.

Reset
REQ-028 While rst_ni = 0, SHALL force state IDLE, counter 0, error flag 0 and captured fields 0.
REQ-029 Reset values of outputs SHALL be: aw_ready_o = 1, w_ready_o = 0, b_valid_o = 0, b_resp_o = 0, b_id_o = 0, mem_req_o = 0, mem_addr_o = 0.
REQ-030 Reset asserted mid-burst or mid-response SHALL abandon the transaction with no B response issued; operation SHALL resume from IDLE after release.

Structure
REQ-031 AXI constants (RESP_OKAY, RESP_SLVERR, BURST_INCR) SHALL come from the shared AXI package; the FSM state enum SHALL be local to the module.
REQ-032 The burst address computation SHALL be one sub-module, axi_burst_addr_gen (inputs: addr, size; output: next addr).

Verification
REQ-033 The bench SHALL cover: AW addr 0x8000_0000, len 0, size 3; W data 0xDEAD_BEEF, strb 0xFF, last 1; mem_gnt_i = 1 -> one mem write to 0x8000_0000 with be 0xFF; B OKAY with matching id on cycle 2.
REQ-034 The bench SHALL cover: AW addr 0x8000_0010, len 3, size 3, INCR; mem_gnt_i held 0 for 2 cycles per beat -> writes to 0x10, 0x18, 0x20, 0x28 (offsets from the base) in order; w_ready_o follows the grant; one B OKAY.
REQ-035 The bench SHALL cover: AW addr 0x1000 (out of region), len 1 -> both beats accepted, mem_req_o never asserted, B SLVERR.
REQ-036 The bench SHALL cover: AW addr 0x8000_0FF8, len 1, size 3 (crosses 4 KiB) -> no memory writes, B SLVERR.
REQ-037 The bench SHALL cover: len 2 with w_last_i asserted on beat 1 -> burst ends after 2 beats, B SLVERR; b_ready_i held 0 for 5 cycles -> B stays stable, then the module returns to IDLE.
REQ-038 The bench SHALL cover: rst_ni pulsed low during DATA after beat 1 -> no B response, aw_ready_o = 1 after release, and the next transaction completes OKAY.
